ofs_plat_host_chan_tx_tlp_arb: RTL and testbench
================================================

Name: ofs_plat_host_chan_tx_tlp_arb

Overview:
- Packet-atomic arbiter sharing the host-channel TX TLP stream between three AFU-side TLP sources: MMIO completions (src 0), read requests (src 1) and write requests (src 2).
- Replaces fixed-priority muxing with three mechanisms:
  - MMIO priority, bounded by a burst limit.
  - Weighted round-robin between read and write.
  - A grant held across multi-beat packets, so no TLP is ever interleaved.
- Sits between the TLP generators and afu_tx_st of the host-channel TLP interface.

Parameters:
- DATA_W, 512, width of one beat (TLP vector data + user, packed).
- RD_WEIGHT, 4, consecutive read packets granted before yielding to write (1..15).
- WR_WEIGHT, 4, consecutive write packets granted before yielding to read (1..15).
- MMIO_BURST_MAX, 8, consecutive MMIO packets before MMIO must yield if rd/wr pending (1..15).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- src_tvalid  in  3  per-source beat valid [0]=MMIO [1]=RD [2]=WR
- src_tready  out  3  per-source ready
- src_tdata  in  3*DATA_W  per-source beat, source i at [i*DATA_W +: DATA_W]
- src_tlast  in  3  per-source end-of-packet marker on the beat
- out_tvalid  out  1  to afu_tx_st
- out_tready  in  1  from afu_tx_st
- out_tdata  out  DATA_W  selected beat
- out_tlast  out  1  selected beat is end of packet
- grant_src  out  2  current/last granted source (3 = none)
- arb_busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE, rr_ptr=RD, rd_cnt=wr_cnt=mmio_run=0, grant_src=3.
  - All src_tready=0, out_tvalid=0.
- States: IDLE, HELD (choice made, beat offered, out_tready low), LOCKED (mid-packet on lock_src).
- IDLE selection (combinational, zero latency), when any src_tvalid:
  - MMIO wins if valid AND (mmio_run < MMIO_BURST_MAX OR neither RD nor WR valid).
  - Otherwise the rr_ptr source wins if valid; else the other of RD/WR wins.
- Output path:
  - out_tvalid = src_tvalid[sel]; out_tdata/out_tlast = source sel.
  - src_tready[sel] = out_tready; all other src_tready = 0.
  - Pure combinational mux; no added latency.
- Transitions:
  - IDLE, sel offered, out_tready=0 → HELD(sel). The choice is frozen until accepted (AXI-S stability), even if a higher-priority source becomes valid.
  - IDLE/HELD, beat accepted, tlast=0 → LOCKED(sel).
  - IDLE/HELD, beat accepted, tlast=1 → IDLE; packet-complete update.
  - LOCKED: only lock_src is muxed. A beat with tlast=1 accepted → IDLE; packet-complete update. src_tvalid low mid-packet → out_tvalid=0, stay LOCKED.
- Packet-complete update for source s:
  - s=MMIO: mmio_run++, saturating at MMIO_BURST_MAX.
  - s=RD/WR: mmio_run=0.
  - s==rr_ptr: cnt[s]++. If cnt reaches the weight, rr_ptr flips and both cnt=0.
  - s!=rr_ptr (preferred source was idle): rr_ptr=s, cnt[s]=1, other cnt=0. If the weight is 1, flip immediately.
  - MMIO packets do not touch rr_ptr/cnt.
- MMIO packet completing while no RD/WR valid: mmio_run still increments but is not enforced (MMIO alone is never stalled).
- grant_src:
  - Updates to sel on every accepted beat.
  - Set to 3 on the cycle a tlast beat is accepted, registered so it is visible the next cycle.
- Back-to-back: a new packet may start the cycle after the tlast beat. One IDLE arbitration occurs per packet, with no bubble.
- Reset mid-packet: returns to IDLE immediately. The partial packet is abandoned; upstream generators are reset together.

Test Plan:
- Only RD valid with 3 single-beat packets, out_tready=1 → 3 beats on consecutive cycles, grant_src=1,1,1 then 3, rd_cnt=3.
- RD and WR continuously valid, single-beat packets, weights 4/4 → output order RD×4, WR×4, RD×4; no bubbles.
- MMIO and RD continuously valid, MMIO_BURST_MAX=8 → 8 MMIO, 1 RD, 8 MMIO; with RD absent, MMIO streams unbroken.
- WR 4-beat packet started, MMIO asserts at beat 2 → WR beats 2–4 complete uninterrupted, MMIO granted the cycle after WR tlast.
- RD offered, out_tready=0 for 5 cycles while MMIO asserts at cycle 2 → out_tdata stays RD beat; RD accepted when ready rises, then MMIO.
- reset_n pulsed low mid-LOCKED on WR → src_tready=0, out_tvalid=0 asynchronously; after release rr_ptr=RD, grant_src=3.

Source files
------------

// File: rtl/ofs_plat_host_chan_tx_tlp_arb.sv
// Packet-atomic TX TLP arbiter for the host channel.
// Three sources share afu_tx_st: MMIO completions (0), read requests (1) and
// write requests (2). MMIO has priority but is bounded by a burst limit while
// RD/WR are waiting. RD and WR share the remaining bandwidth by weighted
// round-robin. A grant is held from the first beat of a packet through its
// tlast beat, so TLPs are never interleaved.
module ofs_plat_host_chan_tx_tlp_arb #(
    parameter int unsigned DATA_W         = 512,
    parameter int unsigned RD_WEIGHT      = 4,
    parameter int unsigned WR_WEIGHT      = 4,
    parameter int unsigned MMIO_BURST_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [2:0]            src_tvalid,
    output logic [2:0]            src_tready,
    input  logic [3*DATA_W-1:0]   src_tdata,
    input  logic [2:0]            src_tlast,

    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [DATA_W-1:0]     out_tdata,
    output logic                  out_tlast,

    output logic [1:0]            grant_src,
    output logic                  arb_busy
);

    localparam logic [1:0] SRC_MMIO = 2'd0;
    localparam logic [1:0] SRC_RD   = 2'd1;
    localparam logic [1:0] SRC_WR   = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    localparam logic [3:0] RD_W     = 4'(RD_WEIGHT);
    localparam logic [3:0] WR_W     = 4'(WR_WEIGHT);
    localparam logic [3:0] MMIO_MAX = 4'(MMIO_BURST_MAX);

    // StHeld: a beat is offered but not yet accepted, choice is frozen.
    // StLocked: mid-packet, only the locked source is muxed.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHeld   = 2'd1,
        StLocked = 2'd2
    } state_t;

    state_t     r_state,      w_state_nxt;
    logic [1:0] r_lock_src,   w_lock_src_nxt;
    logic       r_rr_wr,      w_rr_wr_nxt;     // round-robin pointer: 0 = RD, 1 = WR
    logic [3:0] r_rd_cnt,     w_rd_cnt_nxt;
    logic [3:0] r_wr_cnt,     w_wr_cnt_nxt;
    logic [3:0] r_mmio_run,   w_mmio_run_nxt;
    logic [1:0] r_grant_src,  w_grant_src_nxt;

    logic [1:0] w_arb_src;
    logic [1:0] w_sel;
    logic       w_accept;
    logic       w_pkt_done;
    logic       w_sel_is_wr;
    logic [3:0] w_cur_cnt;
    logic [3:0] w_new_cnt;
    logic [3:0] w_weight;

    // IDLE arbitration: bounded MMIO priority, then weighted RD/WR round-robin.
    always_comb begin
        w_arb_src = SRC_NONE;
        if (src_tvalid[0] && ((r_mmio_run < MMIO_MAX) || (src_tvalid[2:1] == 2'b00))) begin
            w_arb_src = SRC_MMIO;
        end else if (r_rr_wr ? src_tvalid[2] : src_tvalid[1]) begin
            w_arb_src = r_rr_wr ? SRC_WR : SRC_RD;
        end else if (src_tvalid[1]) begin
            w_arb_src = SRC_RD;
        end else if (src_tvalid[2]) begin
            w_arb_src = SRC_WR;
        end
    end

    assign w_sel = (r_state == StIdle) ? w_arb_src : r_lock_src;

    // Output mux; gated by reset_n so outputs drop as soon as reset asserts.
    always_comb begin
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tlast  = 1'b0;
        src_tready = 3'b000;
        if (reset_n) begin
            case (w_sel)
                SRC_MMIO: begin
                    out_tvalid    = src_tvalid[0];
                    out_tdata     = src_tdata[0*DATA_W +: DATA_W];
                    out_tlast     = src_tlast[0];
                    src_tready[0] = out_tready;
                end
                SRC_RD: begin
                    out_tvalid    = src_tvalid[1];
                    out_tdata     = src_tdata[1*DATA_W +: DATA_W];
                    out_tlast     = src_tlast[1];
                    src_tready[1] = out_tready;
                end
                SRC_WR: begin
                    out_tvalid    = src_tvalid[2];
                    out_tdata     = src_tdata[2*DATA_W +: DATA_W];
                    out_tlast     = src_tlast[2];
                    src_tready[2] = out_tready;
                end
                default: ;
            endcase
        end
    end

    assign w_accept   = out_tvalid & out_tready;
    assign w_pkt_done = w_accept & out_tlast;

    // Next-state: freeze the choice until accepted, lock until tlast.
    always_comb begin
        w_state_nxt     = r_state;
        w_lock_src_nxt  = r_lock_src;
        w_grant_src_nxt = r_grant_src;
        case (r_state)
            StIdle: begin
                if (out_tvalid) begin
                    w_lock_src_nxt = w_sel;
                    if (!out_tready) begin
                        w_state_nxt = StHeld;
                    end else if (!out_tlast) begin
                        w_state_nxt = StLocked;
                    end
                end
            end
            StHeld: begin
                // A withdrawn offer falls back to arbitration rather than deadlocking.
                if (!out_tvalid) begin
                    w_state_nxt = StIdle;
                end else if (out_tready) begin
                    w_state_nxt = out_tlast ? StIdle : StLocked;
                end
            end
            StLocked: begin
                if (w_pkt_done) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (w_accept) begin
            w_grant_src_nxt = out_tlast ? SRC_NONE : w_sel;
        end
    end

    // Packet-complete bookkeeping: MMIO run length and RD/WR weighted round-robin.
    always_comb begin
        w_rr_wr_nxt    = r_rr_wr;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_mmio_run_nxt = r_mmio_run;
        w_sel_is_wr    = (w_sel == SRC_WR);
        w_cur_cnt      = w_sel_is_wr ? r_wr_cnt : r_rd_cnt;
        // A packet from the non-preferred source restarts its count at one.
        w_new_cnt      = (w_sel_is_wr == r_rr_wr) ? (w_cur_cnt + 4'd1) : 4'd1;
        w_weight       = w_sel_is_wr ? WR_W : RD_W;
        if (w_pkt_done) begin
            if (w_sel == SRC_MMIO) begin
                if (r_mmio_run < MMIO_MAX) begin
                    w_mmio_run_nxt = r_mmio_run + 4'd1;
                end
            end else if (w_sel != SRC_NONE) begin
                w_mmio_run_nxt = 4'd0;
                if (w_new_cnt >= w_weight) begin
                    w_rr_wr_nxt  = ~w_sel_is_wr;
                    w_rd_cnt_nxt = 4'd0;
                    w_wr_cnt_nxt = 4'd0;
                end else begin
                    w_rr_wr_nxt  = w_sel_is_wr;
                    w_rd_cnt_nxt = w_sel_is_wr ? 4'd0 : w_new_cnt;
                    w_wr_cnt_nxt = w_sel_is_wr ? w_new_cnt : 4'd0;
                end
            end
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_lock_src  <= SRC_NONE;
            r_rr_wr     <= 1'b0;
            r_rd_cnt    <= 4'd0;
            r_wr_cnt    <= 4'd0;
            r_mmio_run  <= 4'd0;
            r_grant_src <= SRC_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_src  <= w_lock_src_nxt;
            r_rr_wr     <= w_rr_wr_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_mmio_run  <= w_mmio_run_nxt;
            r_grant_src <= w_grant_src_nxt;
        end
    end

    // The source of a beat being accepted shows immediately; otherwise the
    // registered value (3 after a tlast beat) is presented.
    assign grant_src = w_accept ? w_sel : r_grant_src;
    assign arb_busy  = (r_state != StIdle);

endmodule

// File: tb/tb_ofs_plat_host_chan_tx_tlp_arb.sv
// Self-checking bench for ofs_plat_host_chan_tx_tlp_arb.
// Sources are fed from per-source beat queues. A packet-level model predicts
// every output each cycle; directed scenarios also check the accepted-beat
// order against hand-written sequences.
module tb_ofs_plat_host_chan_tx_tlp_arb;

    localparam int DW  = 16;
    localparam int RDW = 4;
    localparam int WRW = 4;
    localparam int MB  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [2:0]        src_tvalid = '0;
    logic [2:0]        src_tready;
    logic [3*DW-1:0]   src_tdata = '0;
    logic [2:0]        src_tlast = '0;
    logic              out_tvalid;
    logic              out_tready = 1'b0;
    logic [DW-1:0]     out_tdata;
    logic              out_tlast;
    logic [1:0]        grant_src;
    logic              arb_busy;

    ofs_plat_host_chan_tx_tlp_arb #(
        .DATA_W         (DW),
        .RD_WEIGHT      (RDW),
        .WR_WEIGHT      (WRW),
        .MMIO_BURST_MAX (MB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .src_tvalid (src_tvalid),
        .src_tready (src_tready),
        .src_tdata  (src_tdata),
        .src_tlast  (src_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .grant_src  (grant_src),
        .arb_busy   (arb_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat queues: bit 16 = last, [15:14] = source, [13:8] = packet id, [7:0] = beat.
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] q2[$];
    int          pkt_id = 0;
    logic [2:0]  fired = '0;

    // Log of accepted beats.
    int log_src[$];
    int log_grant[$];
    int log_cyc[$];
    int cyc = 0;

    task automatic push_pkt(input int s, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            logic [16:0] w;
            w = {(b == nbeats - 1) ? 1'b1 : 1'b0, 2'(s), 6'(pkt_id), 8'(b)};
            case (s)
                0: q0.push_back(w);
                1: q1.push_back(w);
                default: q2.push_back(w);
            endcase
        end
        pkt_id++;
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            logic [16:0] h;
            int          sz;
            h  = '0;
            sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
            if (sz > 0) h = (i == 0) ? q0[0] : (i == 1) ? q1[0] : q2[0];
            src_tvalid[i]          = (sz > 0);
            src_tlast[i]           = (sz > 0) ? h[16] : 1'b0;
            src_tdata[i*DW +: DW]  = (sz > 0) ? h[15:0] : '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (fired[0]) void'(q0.pop_front());
        if (fired[1]) void'(q1.pop_front());
        if (fired[2]) void'(q2.pop_front());
        fired = '0;
        drive();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) > 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        pkt_id = 0;
        log_src.delete(); log_grant.delete(); log_cyc.delete();
    endtask

    task automatic check_seq(input string name, input int exp[], input bit contiguous);
        check({name, "_len"}, 32'(log_src.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_src.size(); i++) begin
            check($sformatf("%s_src%0d", name, i), 32'(log_src[i]), 32'(exp[i]));
            if (contiguous)
                check($sformatf("%s_cyc%0d", name, i), 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_owner;      // source owning the link (offer pending or mid-packet), -1 if free
    int m_rr;         // preferred of RD(1)/WR(2)
    int m_cnt[3];
    int m_run;
    int m_grant;

    function automatic void model_reset();
        m_owner = -1; m_rr = 1; m_cnt[1] = 0; m_cnt[2] = 0; m_run = 0; m_grant = 3;
    endfunction

    function automatic void complete(input int s);
        int w;
        if (s == 0) begin
            if (m_run < MB) m_run++;
        end else begin
            m_run = 0;
            w = (s == 1) ? RDW : WRW;
            if (s == m_rr) begin
                m_cnt[s]++;
            end else begin
                m_rr = s; m_cnt[s] = 1; m_cnt[3 - s] = 0;
            end
            if (m_cnt[s] >= w) begin
                m_rr = 3 - s; m_cnt[1] = 0; m_cnt[2] = 0;
            end
        end
    endfunction

    initial model_reset();

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        int         sel;
        logic       ev;
        logic [2:0] er;
        logic       acc;
        int         eg;
        cyc++;
        if (!reset_n) begin
            model_reset();
            fired = '0;
        end else begin
            if (m_owner >= 0) sel = m_owner;
            else if (src_tvalid[0] && (m_run < MB || src_tvalid[2:1] == 2'b00)) sel = 0;
            else if (src_tvalid[m_rr]) sel = m_rr;
            else if (src_tvalid[3 - m_rr]) sel = 3 - m_rr;
            else sel = -1;
            ev = (sel >= 0) ? src_tvalid[sel] : 1'b0;
            er = '0;
            if (sel >= 0) er[sel] = out_tready;
            acc = ev && out_tready;
            eg  = acc ? sel : m_grant;
            check("out_tvalid", 32'(out_tvalid), 32'(ev));
            check("src_tready", 32'(src_tready), 32'(er));
            check("grant_src", 32'(grant_src), 32'(eg));
            check("arb_busy", 32'(arb_busy), 32'(m_owner >= 0));
            if (ev) begin
                check("out_tdata", 32'(out_tdata), 32'(src_tdata[sel*DW +: DW]));
                check("out_tlast", 32'(out_tlast), 32'(src_tlast[sel]));
            end
            if (out_tvalid && out_tready) begin
                log_src.push_back(int'(out_tdata[15:14]));
                log_grant.push_back(int'(grant_src));
                log_cyc.push_back(cyc);
            end
            fired = src_tvalid & src_tready;
            if (ev) begin
                if (acc && src_tlast[sel]) begin
                    complete(sel);
                    m_owner = -1;
                    m_grant = 3;
                end else begin
                    m_owner = sel;
                    if (acc) m_grant = sel;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int e1[]  = '{1, 1, 1};
        int e1b[] = '{1, 2, 2, 1};
        int e2[]  = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
        int e3[]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        int e3b[] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int e4[]  = '{2, 2, 2, 2, 0};
        int e5[]  = '{1, 0};
        int e6[]  = '{1, 2};

        do_reset();
        check("rst_grant", 32'(grant_src), 32'd3);
        check("rst_busy", 32'(arb_busy), 32'd0);

        // 1: RD only, three single-beat packets
        out_tready = 1'b1;
        for (int i = 0; i < 3; i++) push_pkt(1, 1);
        drive();
        drain("s1", 20);
        check_seq("s1", e1, 1'b1);
        for (int i = 0; i < 3 && i < log_grant.size(); i++)
            check($sformatf("s1_grant%0d", i), 32'(log_grant[i]), 32'd1);
        check("s1_grant_idle", 32'(grant_src), 32'd3);
        // rd_cnt is 3: one more RD flips the pointer to WR
        log_src.delete(); log_cyc.delete(); log_grant.delete();
        push_pkt(1, 1); push_pkt(1, 1); push_pkt(2, 1); push_pkt(2, 1);
        drive();
        drain("s1b", 20);
        check_seq("s1b", e1b, 1'b1);

        // 2: RD and WR both pending, weights 4/4
        do_reset();
        out_tready = 1'b1;
        for (int i = 0; i < 8; i++) push_pkt(1, 1);
        for (int i = 0; i < 4; i++) push_pkt(2, 1);
        drive();
        drain("s2", 40);
        check_seq("s2", e2, 1'b1);

        // 3: MMIO with RD pending, then MMIO alone
        do_reset();
        out_tready = 1'b1;
        for (int i = 0; i < 16; i++) push_pkt(0, 1);
        push_pkt(1, 1); push_pkt(1, 1);
        drive();
        drain("s3", 60);
        check_seq("s3", e3, 1'b1);
        log_src.delete(); log_cyc.delete(); log_grant.delete();
        for (int i = 0; i < 12; i++) push_pkt(0, 1);
        drive();
        drain("s3b", 40);
        check_seq("s3b", e3b, 1'b1);

        // 4: MMIO arrives during a 4-beat WR packet
        do_reset();
        out_tready = 1'b1;
        push_pkt(2, 4);
        drive();
        tick();
        push_pkt(0, 1);
        drive();
        drain("s4", 20);
        check_seq("s4", e4, 1'b1);

        // 5: RD offered with out_tready low, MMIO shows up meanwhile
        do_reset();
        out_tready = 1'b0;
        push_pkt(1, 1);
        drive();
        tick(); tick();
        push_pkt(0, 1);
        drive();
        repeat (3) begin
            tick();
            check("s5_hold_data", 32'(out_tdata), 32'h4000);
            check("s5_hold_valid", 32'(out_tvalid), 32'd1);
            check("s5_hold_mmio_rdy", 32'(src_tready[0]), 32'd0);
        end
        out_tready = 1'b1;
        drain("s5", 20);
        check_seq("s5", e5, 1'b1);

        // 6: reset in the middle of a locked WR packet
        do_reset();
        out_tready = 1'b1;
        for (int i = 0; i < 4; i++) push_pkt(1, 1);
        push_pkt(2, 4);
        drive();
        repeat (6) tick();
        check("s6_busy", 32'(arb_busy), 32'd1);
        check("s6_grant_wr", 32'(grant_src), 32'd2);
        reset_n = 1'b0;
        #1;
        check("s6_rst_tready", 32'(src_tready), 32'd0);
        check("s6_rst_tvalid", 32'(out_tvalid), 32'd0);
        check("s6_rst_grant", 32'(grant_src), 32'd3);
        check("s6_rst_busy", 32'(arb_busy), 32'd0);
        do_reset();
        check("s6_post_grant", 32'(grant_src), 32'd3);
        out_tready = 1'b1;
        push_pkt(1, 1); push_pkt(2, 1);
        drive();
        drain("s6", 20);
        check_seq("s6", e6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
